// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-outstanding memory reads and
// buffers returned instructions with their addresses for decode.
module fetch_unit #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic        redirect,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        decode_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [31:0]        buf_instr_q [DEPTH];
  logic [31:0]        buf_instr_d [DEPTH];
  logic [31:0]        buf_pc_q    [DEPTH];
  logic [31:0]        buf_pc_d    [DEPTH];

  logic push;
  logic pop;
  logic issue;

  // Next-state, buffer bookkeeping and request decision.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    req_pc_d    = req_pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    // Head is visible combinationally; a redirect hides it and blocks the pop.
    instr_valid = (count_q != '0) && !redirect;
    instr       = buf_instr_q[rd_ptr_q];
    instr_pc    = buf_pc_q[rd_ptr_q];
    pop         = instr_valid && decode_ready;
    push        = (state_q == WAIT) && imem_rvalid && !redirect;

    // Occupancy after this cycle decides whether a new request still fits.
    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    if (push) begin
      buf_instr_d[wr_ptr_q] = imem_rdata;
      buf_pc_d[wr_ptr_q]    = req_pc_q;
    end

    // Held low while in reset so nothing is requested before release.
    issue = reset_n
          && ((state_q == IDLE) || (((state_q == WAIT) || (state_q == DROP)) && imem_rvalid))
          && (count_d < CNT_W'(DEPTH));

    if (issue) begin
      req_pc_d = pc_in;
    end

    unique case (state_q)
      IDLE: begin
        if (issue) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid)   state_d = issue ? WAIT : IDLE;
        else if (redirect) state_d = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_d = issue ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    imem_req   = issue;
    pc_advance = issue;
    imem_addr  = {pc_in[31:2], 2'b00};
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      req_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_pc_q    <= req_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural PC stage and memory.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_in;
  logic        redirect;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 1;
  int rem      = 0;
  logic [31:0] mem_addr = '0;

  fetch_unit #(.DEPTH(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_in        (pc_in),
    .redirect     (redirect),
    .pc_advance   (pc_advance),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .decode_ready (decode_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a + 32'h1300_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: PC stage steps on pc_advance, memory returns data after lat cycles.
  task automatic tick();
    logic        r;
    logic        a;
    logic [31:0] ad;
    #1;
    r  = imem_req;
    a  = pc_advance;
    ad = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (a) pc_in = pc_in + 32'd4;
    if (r) begin
      rem      = lat;
      mem_addr = ad;
    end
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mdata(mem_addr);
      end
    end
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    pc_in        = 32'h0;
    redirect     = 1'b0;
    decode_ready = 1'b1;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;

    // Reset state
    #2;
    check("rst_req",   {31'b0, imem_req},    32'h0);
    check("rst_adv",   {31'b0, pc_advance},  32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr,                32'h0);
    check("rst_ipc",   instr_pc,             32'h0);
    tick();
    tick();

    // Streaming after release, 1-cycle memory
    reset_n = 1'b1;
    #1;
    check("c0_req",   {31'b0, imem_req},   32'h1);
    check("c0_adv",   {31'b0, pc_advance}, 32'h1);
    check("c0_addr",  imem_addr,           32'h0);
    tick();
    check("c1_valid", {31'b0, instr_valid}, 32'h0);
    check("c1_req",   {31'b0, imem_req},    32'h1);
    check("c1_addr",  imem_addr,            32'h4);
    tick();
    check("c2_valid", {31'b0, instr_valid}, 32'h1);
    check("c2_ipc",   instr_pc,             32'h0);
    check("c2_instr", instr,                mdata(32'h0));
    check("c2_addr",  imem_addr,            32'h8);
    tick();
    check("c3_ipc",   instr_pc,             32'h4);
    check("c3_instr", instr,                mdata(32'h4));
    check("c3_addr",  imem_addr,            32'hC);

    // Decode stall fills the buffer and stops fetching
    decode_ready = 1'b0;
    #1;
    check("st3_req",  {31'b0, imem_req},    32'h0);
    check("st3_adv",  {31'b0, pc_advance},  32'h0);
    tick();
    check("st4_req",  {31'b0, imem_req},    32'h0);
    check("st4_ipc",  instr_pc,             32'h4);
    tick();
    check("st5_req",  {31'b0, imem_req},    32'h0);
    check("st5_ipc",  instr_pc,             32'h4);
    check("st5_pc",   pc_in,                32'hC);
    decode_ready = 1'b1;
    #1;
    check("res_req",  {31'b0, imem_req},    32'h1);
    check("res_adv",  {31'b0, pc_advance},  32'h1);
    check("res_addr", imem_addr,            32'hC);
    tick();
    check("c6_ipc",   instr_pc,             32'h8);
    check("c6_addr",  imem_addr,            32'h10);

    // Redirect with a 3-cycle read outstanding
    lat = 3;
    tick();
    check("c7_ipc",   instr_pc,             32'hC);
    check("c7_req",   {31'b0, imem_req},    32'h0);
    redirect = 1'b1;
    pc_in    = 32'h100;
    #1;
    check("rd7_valid", {31'b0, instr_valid}, 32'h0);
    check("rd7_req",   {31'b0, imem_req},    32'h0);
    tick();
    redirect = 1'b0;
    #1;
    check("drop8_valid", {31'b0, instr_valid}, 32'h0);
    check("drop8_req",   {31'b0, imem_req},    32'h0);
    lat = 1;
    tick();
    check("drop9_rv",    {31'b0, imem_rvalid}, 32'h1);
    check("drop9_req",   {31'b0, imem_req},    32'h1);
    check("drop9_addr",  imem_addr,            32'h100);
    check("drop9_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    check("c10_valid", {31'b0, instr_valid}, 32'h0);
    check("c10_addr",  imem_addr,            32'h104);
    tick();
    check("c11_valid", {31'b0, instr_valid}, 32'h1);
    check("c11_ipc",   instr_pc,             32'h100);
    check("c11_instr", instr,                mdata(32'h100));

    // Redirect coincident with read data
    redirect = 1'b1;
    pc_in    = 32'h40;
    #1;
    check("rv11_req",   {31'b0, imem_req},    32'h1);
    check("rv11_addr",  imem_addr,            32'h40);
    check("rv11_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    check("c12_valid", {31'b0, instr_valid}, 32'h0);
    check("c12_addr",  imem_addr,            32'h44);
    tick();
    check("c13_ipc",   instr_pc,             32'h40);
    check("c13_instr", instr,                mdata(32'h40));

    // Unaligned redirect target
    redirect = 1'b1;
    pc_in    = 32'h103;
    #1;
    check("ua_addr", imem_addr,           32'h100);
    check("ua_req",  {31'b0, imem_req},   32'h1);
    tick();
    redirect = 1'b0;
    #1;
    check("c14_valid", {31'b0, instr_valid}, 32'h0);
    check("c14_addr",  imem_addr,            32'h104);
    tick();
    check("c15_valid", {31'b0, instr_valid}, 32'h1);
    check("c15_ipc",   instr_pc,             32'h103);
    check("c15_instr", instr,                mdata(32'h100));

    // Reset with a read outstanding; its late data must be ignored
    lat = 3;
    tick();
    reset_n = 1'b0;
    #1;
    check("ar_req",   {31'b0, imem_req},    32'h0);
    check("ar_adv",   {31'b0, pc_advance},  32'h0);
    check("ar_valid", {31'b0, instr_valid}, 32'h0);
    check("ar_instr", instr,                32'h0);
    check("ar_ipc",   instr_pc,             32'h0);
    tick();
    tick();
    check("late_rv",  {31'b0, imem_rvalid}, 32'h1);
    reset_n = 1'b1;
    pc_in   = 32'h200;
    lat     = 1;
    #1;
    check("rel_req",   {31'b0, imem_req},    32'h1);
    check("rel_addr",  imem_addr,            32'h200);
    check("rel_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    check("c19_valid", {31'b0, instr_valid}, 32'h0);
    check("c19_addr",  imem_addr,            32'h204);
    tick();
    check("c20_valid", {31'b0, instr_valid}, 32'h1);
    check("c20_ipc",   instr_pc,             32'h200);
    check("c20_instr", instr,                mdata(32'h200));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
